// File: rtl/truth_table_extractor_pkg.sv
// Shared definitions for the truth-table extractor.
// Contents: default input count, truth-table width, FSM state type, and the
// index-to-bit-position helper that the score tooling also uses.
package tt_pkg;

  localparam int N_IN_DEFAULT = 3;
  localparam int TT_W         = 2 ** N_IN_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Combination 000 lands in the MSB of the code, so the position is mirrored.
  function automatic int tt_bit_pos(input int idx, input int tt_w = TT_W);
    return tt_w - 1 - idx;
  endfunction

endpackage

// File: rtl/truth_table_extractor_if.sv
// Bus between the characterisation bench and the truth-table extractor.
// master: drives start/expected_tt/dut_out, observes the results.
// slave : the extractor; drives dut_in, busy, done, truth_table, match.
interface truth_table_extractor_if #(
  parameter int N_IN = tt_pkg::N_IN_DEFAULT
);
  localparam int TT_W = 2 ** N_IN;

  logic            start;
  logic [TT_W-1:0] expected_tt;
  logic            dut_out;
  logic [N_IN-1:0] dut_in;
  logic            busy;
  logic            done;
  logic [TT_W-1:0] truth_table;
  logic            match;

  modport master (
    output start, expected_tt, dut_out,
    input  dut_in, busy, done, truth_table, match
  );

  modport slave (
    input  start, expected_tt, dut_out,
    output dut_in, busy, done, truth_table, match
  );
endinterface

// File: rtl/truth_table_extractor_settle_counter.sv
// Settle-interval down-counter.
// Ports: clk, rst (sync, active high), i_load + i_load_val (load has priority),
// i_dec (decrement, saturates at zero), o_zero (count is zero).
module settle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/truth_table_extractor.sv
// Truth-table extractor: walks a combinational netlist through every input
// combination, holds each for SETTLE_CYCLES, samples its output and assembles
// the hex truth-table code (combination 000 in the MSB), then compares it
// with the code latched at start.
// Ports: clk, rst (sync, active high), bus (slave modport: start,
// expected_tt, dut_out in; dut_in, busy, done, truth_table, match out).
module truth_table_extractor
  import tt_pkg::*;
#(
  parameter int N_IN          = tt_pkg::N_IN_DEFAULT,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  truth_table_extractor_if.slave bus
);

  localparam int LP_TT_W = 2 ** N_IN;
  localparam int IDX_W   = N_IN + 1;  // one spare bit: no wrap at the last index
  localparam int POS_W   = N_IN;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [N_IN-1:0]     r_dut_in;
  logic [LP_TT_W-1:0]  r_tt;
  logic [LP_TT_W-1:0]  r_expected;
  logic                r_busy;
  logic                r_done;
  logic                r_match;

  logic                w_last;
  logic [POS_W-1:0]    w_pos;
  logic                w_load;
  logic                w_dec;
  logic                w_zero;

  assign w_last = (r_idx == IDX_W'(LP_TT_W - 1));
  assign w_pos  = POS_W'(tt_bit_pos(int'(r_idx), LP_TT_W));
  assign w_load = ((r_state == IDLE) && bus.start) ||
                  ((r_state == SAMPLE) && !w_last);
  assign w_dec  = (r_state == SETTLE);

  settle_counter #(
    .W (8)
  ) u_settle (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (8'(SETTLE_CYCLES - 1)),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_dut_in   <= '0;
      r_tt       <= '0;
      r_expected <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          if (bus.start) begin
            r_expected <= bus.expected_tt;
            r_tt       <= '0;
            r_match    <= 1'b0;
            r_idx      <= '0;
            r_dut_in   <= '0;
            r_busy     <= 1'b1;
            r_state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_zero) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_tt[w_pos] <= bus.dut_out;
          if (w_last) begin
            r_state <= DONE;
          end else begin
            // dut_in mirrors the low bits of idx
            r_idx    <= r_idx + 1'b1;
            r_dut_in <= r_dut_in + 1'b1;
            r_state  <= SETTLE;
          end
        end
        DONE: begin
          // The last sample is already in r_tt, so the compare is exact here.
          r_done   <= 1'b1;
          r_match  <= (r_tt == r_expected);
          r_dut_in <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dut_in      = r_dut_in;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.truth_table = r_tt;
  assign bus.match       = r_match;

endmodule

// File: tb/tb_truth_table_extractor.sv
module tb_truth_table_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_b;
  logic [7:0] exp_b;
  int         mode0, mode1;
  logic [7:0] code0, code1;

  int n_vec = 0;
  int n_err = 0;

  truth_table_extractor_if #(.N_IN(3)) if0 ();
  truth_table_extractor_if #(.N_IN(3)) if1 ();

  truth_table_extractor #(.N_IN(3), .SETTLE_CYCLES(4)) u_dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  truth_table_extractor #(.N_IN(3), .SETTLE_CYCLES(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );

  // DUT netlist models: 0 = gate form of 0xC7, 1 = out=in3, 2 = tied 1,
  // 3 = tied 0, other = lookup of an arbitrary code.
  function automatic logic dut_model(input int mode, input logic [7:0] code,
                                     input logic [2:0] v);
    logic a, b, c;
    int   p;
    {a, b, c} = v;
    p = 7 - int'(v);
    case (mode)
      0:       return ~((a & ~b & ~c) | (b & ~a));
      1:       return c;
      2:       return 1'b1;
      3:       return 1'b0;
      default: return code[p];
    endcase
  endfunction

  function automatic logic [7:0] ref_tt(input int mode, input logic [7:0] code);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[7-i] = dut_model(mode, code, 3'(i));
    return r;
  endfunction

  assign if0.start       = start_b;
  assign if1.start       = start_b;
  assign if0.expected_tt = exp_b;
  assign if1.expected_tt = exp_b;
  always_comb if0.dut_out = dut_model(mode0, code0, if0.dut_in);
  always_comb if1.dut_out = dut_model(mode1, code1, if1.dut_in);

  function automatic logic g_done(input int sel);
    return (sel != 0) ? if1.done : if0.done;
  endfunction
  function automatic logic g_busy(input int sel);
    return (sel != 0) ? if1.busy : if0.busy;
  endfunction
  function automatic logic g_match(input int sel);
    return (sel != 0) ? if1.match : if0.match;
  endfunction
  function automatic logic [2:0] g_din(input int sel);
    return (sel != 0) ? if1.dut_in : if0.dut_in;
  endfunction
  function automatic logic [7:0] g_tt(input int sel);
    return (sel != 0) ? if1.truth_table : if0.truth_table;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while ((if0.busy !== 1'b0 || if1.busy !== 1'b0) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (k >= 200) begin
      n_err++;
      $display("FAIL wait_idle: busy0=%b busy1=%b still high after %0d cycles", if0.busy, if1.busy, k);
    end
  endtask

  // One run: start is pulsed, cycle 0 is sampled 1 time unit after the edge
  // that accepts start. Checks dut_in stepping and busy every cycle.
  task automatic run(input int sel, input logic [7:0] exp, input int repulse_at,
                     input int rst_at, output logic [7:0] tt, output logic m,
                     output int done_cyc, output int done_w);
    int s, t, c_end;
    s        = (sel != 0) ? 1 : 4;
    t        = 8 * (s + 1) + 1;
    c_end    = (rst_at >= 0) ? rst_at + t + 5 : t + 1;
    done_cyc = -1;
    done_w   = 0;
    tt       = 'x;
    m        = 1'bx;
    exp_b    = exp;
    start_b  = 1'b1;
    @(posedge clk); #1;
    start_b  = 1'b0;
    for (int c = 0; c <= c_end; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      start_b = 1'b0;
      if (rst_at >= 0 && c == rst_at + 1) begin
        rst = 1'b0;
        n_vec++;
        if ({if0.dut_in, if0.busy, if0.done, if0.truth_table, if0.match} !== 14'b0) begin
          n_err++;
          $display("FAIL mid_rst_clear: din=%h busy=%b done=%b tt=%h match=%b, all required 0",
                   if0.dut_in, if0.busy, if0.done, if0.truth_table, if0.match);
        end
      end
      if (g_done(sel) === 1'b1) begin
        if (done_cyc < 0) done_cyc = c;
        done_w++;
        tt = g_tt(sel);
        m  = g_match(sel);
      end
      if (rst_at < 0 || c <= rst_at) begin
        if (c < 8 * (s + 1)) begin
          n_vec++;
          if (g_din(sel) !== 3'(c / (s + 1))) begin
            n_err++;
            $display("FAIL dut_in_step: cycle %0d got %0d required %0d", c, g_din(sel), c / (s + 1));
          end
        end
        n_vec++;
        if (g_busy(sel) !== (c <= t)) begin
          n_err++;
          $display("FAIL busy: cycle %0d got %b required %b", c, g_busy(sel), (c <= t));
        end
      end
      if (c == repulse_at) begin
        start_b = 1'b1;
        exp_b   = ~exp;
      end
      if (c == rst_at) rst = 1'b1;
    end
    rst = 1'b0;
    wait_idle();
  endtask

  task automatic check_result(input string name, input logic [7:0] tt,
                              input logic [7:0] tt_req, input logic m,
                              input logic m_req, input int dc, input int dc_req,
                              input int dw);
    n_vec++;
    if (tt !== tt_req) begin
      n_err++;
      $display("FAIL %s_tt: got %h required %h", name, tt, tt_req);
    end
    n_vec++;
    if (m !== m_req) begin
      n_err++;
      $display("FAIL %s_match: got %b required %b", name, m, m_req);
    end
    n_vec++;
    if (dc != dc_req) begin
      n_err++;
      $display("FAIL %s_done_cycle: got %0d required %0d", name, dc, dc_req);
    end
    n_vec++;
    if (dw != 1) begin
      n_err++;
      $display("FAIL %s_done_width: got %0d required 1", name, dw);
    end
    $display("run %s: tt=%h match=%b done@%0d width=%0d", name, tt, m, dc, dw);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({if0.dut_in, if0.busy, if0.done, if0.truth_table, if0.match} !== 14'b0) begin
      n_err++;
      $display("FAIL reset_dut0: din=%h busy=%b done=%b tt=%h match=%b, all required 0",
               if0.dut_in, if0.busy, if0.done, if0.truth_table, if0.match);
    end
    n_vec++;
    if ({if1.dut_in, if1.busy, if1.done, if1.truth_table, if1.match} !== 14'b0) begin
      n_err++;
      $display("FAIL reset_dut1: din=%h busy=%b done=%b tt=%h match=%b, all required 0",
               if1.dut_in, if1.busy, if1.done, if1.truth_table, if1.match);
    end
    rst = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_c7();
    logic [7:0] tt; logic m; int dc, dw;
    mode0 = 0;
    run(0, 8'hC7, -1, -1, tt, m, dc, dw);
    check_result("c7_match", tt, 8'hC7, m, 1'b1, dc, 41, dw);
    run(0, 8'h00, -1, -1, tt, m, dc, dw);
    check_result("c7_mismatch", tt, 8'hC7, m, 1'b0, dc, 41, dw);
  endtask

  task automatic test_const();
    logic [7:0] tt; logic m; int dc, dw;
    mode1 = 2;
    run(1, 8'hFF, -1, -1, tt, m, dc, dw);
    check_result("tied1", tt, 8'hFF, m, 1'b1, dc, 17, dw);
    mode1 = 3;
    run(1, 8'hFF, -1, -1, tt, m, dc, dw);
    check_result("tied0", tt, 8'h00, m, 1'b0, dc, 17, dw);
  endtask

  task automatic test_repulse();
    logic [7:0] tt; logic m; int dc, dw;
    mode0 = 1;
    run(0, 8'h55, 10, -1, tt, m, dc, dw);
    check_result("repulse", tt, 8'h55, m, 1'b1, dc, 41, dw);
  endtask

  task automatic test_mid_reset();
    logic [7:0] tt; logic m; int dc, dw;
    mode0 = 4;
    code0 = 8'($urandom);
    run(0, code0, -1, 20, tt, m, dc, dw);
    n_vec++;
    if (dw != 0) begin
      n_err++;
      $display("FAIL mid_rst_no_done: got %0d done cycles required 0", dw);
    end
    run(0, code0, -1, -1, tt, m, dc, dw);
    check_result("after_rst", tt, ref_tt(4, code0), m, 1'b1, dc, 41, dw);
  endtask

  task automatic test_back_to_back();
    logic [7:0] tt; logic m; int dc, dw;
    mode0 = 0;
    run(0, 8'hC7, -1, -1, tt, m, dc, dw);
    check_result("b2b_first", tt, 8'hC7, m, 1'b1, dc, 41, dw);
    mode0 = 1;
    run(0, 8'hC7, -1, -1, tt, m, dc, dw);
    check_result("b2b_second", tt, 8'h55, m, 1'b0, dc, 41, dw);
  endtask

  task automatic test_random();
    logic [7:0] tt; logic m; int dc, dw, sel;
    logic [7:0] code, exp, want;
    for (int i = 0; i < 6; i++) begin
      sel  = int'($urandom_range(0, 1));
      code = 8'($urandom);
      exp  = ($urandom_range(0, 1) != 0) ? code : 8'($urandom);
      want = ref_tt(4, code);
      if (sel != 0) begin mode1 = 4; code1 = code; end
      else          begin mode0 = 4; code0 = code; end
      run(sel, exp, -1, -1, tt, m, dc, dw);
      check_result("random", tt, want, m, (want == exp), dc, (sel != 0) ? 17 : 41, dw);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start_b = 1'b0;
    exp_b   = 8'h00;
    mode0   = 3;
    mode1   = 3;
    code0   = 8'h00;
    code1   = 8'h00;
    test_reset();
    @(posedge clk); #1;
    test_c7();
    test_const();
    test_repulse();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
